// File: rtl/ssp_uart_pkg.sv
// Shared types and constants for the SSP UART register-port access controller.
package ssp_uart_pkg;

    localparam int SSP_DW = 12;
    localparam int SSP_AW = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        EOC  = 3'd3,
        DONE = 3'd4,
        GAP  = 3'd5
    } state_t;

    // UART core register map as seen on the SSP slave port
    localparam logic [SSP_AW-1:0] UART_RA_CTRL = 3'd0;
    localparam logic [SSP_AW-1:0] UART_RA_STAT = 3'd1;
    localparam logic [SSP_AW-1:0] UART_RA_TXD  = 3'd2;
    localparam logic [SSP_AW-1:0] UART_RA_RXD  = 3'd3;
    localparam logic [SSP_AW-1:0] UART_RA_BAUD = 3'd4;
    localparam logic [SSP_AW-1:0] UART_RA_FIFO = 3'd5;

endpackage

// File: rtl/ssp_rr_arb.sv
// Round-robin winner selection: lowest requesting index at or after the pointer,
// with wrap-around; the pointer moves past the winner only when a grant is taken.
module ssp_rr_arb #(
    parameter int  NUM_REQ = 4,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               any,
    output logic [IW-1:0]      win_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] j;

    always_comb begin
        any     = 1'b0;
        win_idx = '0;
        j       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = IW'((32'(ptr) + 32'(k)) % NUM_REQ);
            if (!any && req[j]) begin
                any     = 1'b1;
                win_idx = j;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && any) begin
            ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
        end
    end

endmodule

// File: rtl/ssp_uart_access_arb.sv
// Multi-client round-robin access controller for the SSP UART register port.
// Optional IRQ status service frame enabled by defining SSP_UART_IRQ_SVC_EN.
module ssp_uart_access_arb
    import ssp_uart_pkg::*;
#(
    parameter int                NUM_REQ     = 4,
    parameter int                GAP_CYC     = 2,
    parameter logic [SSP_AW-1:0] IRQ_STAT_RA = UART_RA_STAT,
    localparam int               IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [SSP_AW*NUM_REQ-1:0] req_ra,
    input  logic [NUM_REQ-1:0]        req_wnr,
    input  logic [SSP_DW*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [SSP_DW-1:0]         rdata,
    output logic                      busy,
    output logic                      SSP_SSEL,
    output logic [SSP_AW-1:0]         SSP_RA,
    output logic                      SSP_WnR,
    output logic                      SSP_En,
    output logic                      SSP_EOC,
    output logic [SSP_DW-1:0]         SSP_DI,
    input  logic [SSP_DW-1:0]         SSP_DO,
    input  logic                      IRQ,
`ifdef SSP_UART_IRQ_SVC_EN
    output logic [SSP_DW-1:0]         irq_status,
    output logic                      irq_status_vld,
`endif
    output state_t                    fsm_state
);

    // Handshake: a client raises req with its ra/wnr/wdata stable and holds it
    // until done[i] pulses; gnt[i] marks the frame in flight, done[i] closes it.

    state_t              state, next_state;
    logic                start, take_irq, int_frame, in_frame;
    logic                any_req;
    logic [IW-1:0]       win_idx, sel_idx;
    logic [NUM_REQ-1:0]  sel_oh;
    logic [SSP_AW-1:0]   ra_q;
    logic                wnr_q;
    logic [SSP_DW-1:0]   di_q;
    logic [3:0]          gap_cnt;
    logic [SSP_AW-1:0]   ra_arr [NUM_REQ];
    logic [SSP_DW-1:0]   wd_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign ra_arr[i] = req_ra[i*SSP_AW +: SSP_AW];
        assign wd_arr[i] = req_wdata[i*SSP_DW +: SSP_DW];
    end

    ssp_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (Clk),
        .rst     (Rst),
        .req     (req),
        .advance (start && !take_irq),
        .any     (any_req),
        .win_idx (win_idx)
    );

`ifdef SSP_UART_IRQ_SVC_EN
    logic irq_q, irq_pend, int_q, irq_rise;

    // A same-cycle rising edge counts as pending so it beats a simultaneous req
    assign irq_rise  = IRQ && !irq_q;
    assign take_irq  = irq_pend || irq_rise;
    assign int_frame = int_q;
    assign irq_status_vld = (state == DONE) && int_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            irq_q      <= 1'b0;
            irq_pend   <= 1'b0;
            int_q      <= 1'b0;
            irq_status <= '0;
        end else begin
            irq_q <= IRQ;
            if (irq_rise)
                irq_pend <= 1'b1;
            else if (state == DONE && int_q)
                irq_pend <= 1'b0;
            if (start)
                int_q <= take_irq;
            if (state == EOC && int_q)
                irq_status <= SSP_DO;
        end
    end
`else
    logic unused_irq;

    assign take_irq   = 1'b0;
    assign int_frame  = 1'b0;
    assign unused_irq = ^{IRQ, IRQ_STAT_RA};
`endif

    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (take_irq || any_req) begin
                    start      = 1'b1;
                    next_state = ADDR;
                end
            end
            ADDR:    next_state = DATA;
            DATA:    next_state = EOC;
            EOC:     next_state = DONE;
            DONE:    next_state = (GAP_CYC == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == 4'(GAP_CYC - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            sel_idx <= '0;
            ra_q    <= '0;
            wnr_q   <= 1'b0;
            di_q    <= '0;
            rdata   <= '0;
        end else begin
            state   <= next_state;
            gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
            if (start) begin
                if (take_irq) begin
                    ra_q  <= IRQ_STAT_RA;
                    wnr_q <= 1'b0;
                    di_q  <= '0;
                end else begin
                    sel_idx <= win_idx;
                    ra_q    <= ra_arr[win_idx];
                    wnr_q   <= req_wnr[win_idx];
                    di_q    <= req_wnr[win_idx] ? wd_arr[win_idx] : '0;
                end
            end
            if (state == EOC && !wnr_q && !int_frame)
                rdata <= SSP_DO;
        end
    end

    assign in_frame  = (state == ADDR) || (state == DATA) || (state == EOC);
    assign sel_oh    = NUM_REQ'(1) << sel_idx;

    assign SSP_SSEL  = in_frame;
    assign SSP_RA    = in_frame ? ra_q : '0;
    assign SSP_WnR   = in_frame && wnr_q;
    assign SSP_DI    = in_frame ? di_q : '0;
    assign SSP_En    = (state == DATA);
    assign SSP_EOC   = (state == EOC);
    assign busy      = (state != IDLE);
    assign gnt       = (in_frame && !int_frame) ? sel_oh : '0;
    assign done      = (state == DONE && !int_frame) ? sel_oh : '0;
    assign fsm_state = state;

endmodule

// File: tb/tb_ssp_uart_access_arb.sv
// Self-checking bench for ssp_uart_access_arb (NUM_REQ=4, GAP_CYC=2).
module tb_ssp_uart_access_arb;
    import ssp_uart_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [3:0]  req;
    logic [11:0] req_ra;
    logic [3:0]  req_wnr;
    logic [47:0] req_wdata;
    logic [3:0]  gnt, done;
    logic [11:0] rdata;
    logic        busy, SSP_SSEL, SSP_WnR, SSP_En, SSP_EOC;
    logic [2:0]  SSP_RA;
    logic [11:0] SSP_DI, SSP_DO;
    logic        IRQ;
    state_t      fsm_state;
`ifdef SSP_UART_IRQ_SVC_EN
    logic [11:0] irq_status;
    logic        irq_status_vld;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [11:0] model_rdata = '0;

    always #5 Clk = ~Clk;

    ssp_uart_access_arb #(.NUM_REQ(4), .GAP_CYC(2)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req       (req),
        .req_ra    (req_ra),
        .req_wnr   (req_wnr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .SSP_SSEL  (SSP_SSEL),
        .SSP_RA    (SSP_RA),
        .SSP_WnR   (SSP_WnR),
        .SSP_En    (SSP_En),
        .SSP_EOC   (SSP_EOC),
        .SSP_DI    (SSP_DI),
        .SSP_DO    (SSP_DO),
        .IRQ       (IRQ),
`ifdef SSP_UART_IRQ_SVC_EN
        .irq_status     (irq_status),
        .irq_status_vld (irq_status_vld),
`endif
        .fsm_state (fsm_state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_client(input int i, input logic [2:0] ra, input logic wnr, input logic [11:0] wd);
        req_ra[i*3 +: 3]     = ra;
        req_wnr[i]           = wnr;
        req_wdata[i*12 +: 12] = wd;
    endtask

    task automatic apply_reset();
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        model_rdata = '0;
    endtask

    // Bounded wait for a done pulse; d stays 0 when the budget expires
    task automatic wait_done(input int budget, output logic [3:0] d, output logic [11:0] rd, output int cyc);
        d = '0; rd = '0; cyc = 0;
        while (cyc < budget) begin
            @(negedge Clk);
            cyc++;
            if (done !== 4'b0) begin
                d  = done;
                rd = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        req = '0; req_ra = '0; req_wnr = '0; req_wdata = '0; SSP_DO = '0; IRQ = 1'b0;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        n_vec++;
        if ({gnt, done, busy} !== 9'b0) begin
            n_err++; $display("FAIL reset_ctl: got gnt=%b done=%b busy=%b want all 0", gnt, done, busy);
        end
        n_vec++;
        if ({SSP_SSEL, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI} !== 19'b0) begin
            n_err++; $display("FAIL reset_ssp: got sel=%b ra=%h wnr=%b en=%b eoc=%b di=%h want all 0",
                              SSP_SSEL, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI);
        end
        n_vec++;
        if (rdata !== 12'h000) begin
            n_err++; $display("FAIL reset_rdata: got %h want 000", rdata);
        end
        n_vec++;
        if (fsm_state !== IDLE) begin
            n_err++; $display("FAIL reset_state: got %0d want %0d", fsm_state, IDLE);
        end
        Rst = 1'b0;
        model_rdata = '0;
        @(negedge Clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_write();
        logic [15:0] e; logic [3:0] d; logic [11:0] rd; int cyc; logic [2:0] bz;
        set_client(0, 3'd3, 1'b1, 12'h5A5);
        req = 4'b0001;
        exp_q.push_back({4'd0, model_rdata});
        @(negedge Clk);
        n_vec++;
        if ({SSP_SSEL, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, gnt} !== {1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 4'b0001}) begin
            n_err++; $display("FAIL wr_addr: got sel=%b ra=%h wnr=%b en=%b eoc=%b gnt=%b want 1 3 1 0 0 0001",
                              SSP_SSEL, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, gnt);
        end
        @(negedge Clk);
        n_vec++;
        if ({SSP_En, SSP_DI, SSP_RA, SSP_EOC} !== {1'b1, 12'h5A5, 3'd3, 1'b0}) begin
            n_err++; $display("FAIL wr_data: got en=%b di=%h ra=%h eoc=%b want 1 5a5 3 0", SSP_En, SSP_DI, SSP_RA, SSP_EOC);
        end
        @(negedge Clk);
        n_vec++;
        if ({SSP_EOC, SSP_En, SSP_SSEL, SSP_DI} !== {3'b101, 12'h5A5}) begin
            n_err++; $display("FAIL wr_eoc: got eoc=%b en=%b sel=%b di=%h want 1 0 1 5a5", SSP_EOC, SSP_En, SSP_SSEL, SSP_DI);
        end
        wait_done(1, d, rd, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if (d !== (4'b1 << e[15:12]) || rd !== e[11:0]) begin
            n_err++; $display("FAIL wr_done: got done=%b rdata=%h want done=%b rdata=%h", d, rd, 4'b1 << e[15:12], e[11:0]);
        end
        n_vec++;
        if ({SSP_SSEL, gnt, busy} !== 6'b000001) begin
            n_err++; $display("FAIL wr_done_ssp: got sel=%b gnt=%b busy=%b want 0 0000 1", SSP_SSEL, gnt, busy);
        end
        req = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            bz[2-i] = busy;
        end
        n_vec++;
        if (bz !== 3'b110) begin
            n_err++; $display("FAIL wr_gap_busy: got %b want 110", bz);
        end
    endtask

    task automatic test_read();
        logic [15:0] e; logic [3:0] d; logic [11:0] rd; int cyc;
        SSP_DO = 12'h123;
        set_client(2, 3'd5, 1'b0, 12'hFFF);
        req = 4'b0100;
        model_rdata = 12'h123;
        exp_q.push_back({4'd2, model_rdata});
        @(negedge Clk);
        n_vec++;
        if ({SSP_RA, SSP_WnR, gnt} !== {3'd5, 1'b0, 4'b0100}) begin
            n_err++; $display("FAIL rd_addr: got ra=%h wnr=%b gnt=%b want 5 0 0100", SSP_RA, SSP_WnR, gnt);
        end
        @(negedge Clk);
        n_vec++;
        if ({SSP_En, SSP_DI} !== {1'b1, 12'h000}) begin
            n_err++; $display("FAIL rd_data: got en=%b di=%h want 1 000", SSP_En, SSP_DI);
        end
        wait_done(10, d, rd, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if (d !== (4'b1 << e[15:12]) || rd !== e[11:0]) begin
            n_err++; $display("FAIL rd_done: got done=%b rdata=%h want done=%b rdata=%h", d, rd, 4'b1 << e[15:12], e[11:0]);
        end
        n_vec++;
        if (cyc !== 2) begin
            n_err++; $display("FAIL rd_latency: got %0d want 2 cycles after data", cyc);
        end
        req = '0;
        SSP_DO = 12'hABC;
        repeat (8) @(negedge Clk);
        n_vec++;
        if (rdata !== model_rdata) begin
            n_err++; $display("FAIL rd_hold: got %h want %h", rdata, model_rdata);
        end
    endtask

    task automatic test_contention();
        logic [15:0] e; logic [3:0] d; logic [11:0] rd; int cyc;
        int order[5] = '{0, 1, 2, 3, 0};
        logic [11:0] dov[5];
        apply_reset();
        for (int i = 0; i < 4; i++)
            set_client(i, 3'($urandom_range(0, 7)), (i % 2) == 1, 12'($urandom_range(0, 4095)));
        for (int k = 0; k < 5; k++) begin
            dov[k] = 12'($urandom_range(0, 4095));
            if (!req_wnr[order[k]]) model_rdata = dov[k];
            exp_q.push_back({4'(order[k]), model_rdata});
        end
        SSP_DO = dov[0];
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_done(20, d, rd, cyc);
            e = exp_q.pop_front();
            n_vec++;
            if (d !== (4'b1 << e[15:12]) || rd !== e[11:0]) begin
                n_err++; $display("FAIL rr_done[%0d]: got done=%b rdata=%h want done=%b rdata=%h",
                                  k, d, rd, 4'b1 << e[15:12], e[11:0]);
            end
            n_vec++;
            if (cyc !== ((k == 0) ? 4 : 7)) begin
                n_err++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", k, cyc, (k == 0) ? 4 : 7);
            end
            if (k < 4) SSP_DO = dov[k+1];
        end
        req = '0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_reset_mid();
        logic [15:0] e; logic [3:0] d; logic [11:0] rd; int cyc; logic seen;
        set_client(2, 3'd6, 1'b1, 12'h3C3);
        req = 4'b0100;
        repeat (2) @(negedge Clk);
        n_vec++;
        if (SSP_En !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_pre: got en=%b want 1", SSP_En);
        end
        Rst = 1'b1;
        @(negedge Clk);
        n_vec++;
        if ({SSP_SSEL, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI, gnt, done, busy} !== 28'b0) begin
            n_err++; $display("FAIL rst_mid_abort: got sel=%b ra=%h wnr=%b en=%b eoc=%b di=%h gnt=%b done=%b busy=%b want all 0",
                              SSP_SSEL, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI, gnt, done, busy);
        end
        Rst = 1'b0;
        req = '0;
        model_rdata = '0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge Clk);
            if (done !== 4'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_no_done: got activity=%b want 0", seen);
        end
        // pointer back at 0: client 1 must beat client 3
        set_client(1, 3'd2, 1'b0, 12'h000);
        set_client(3, 3'd4, 1'b1, 12'h777);
        SSP_DO = 12'h456;
        model_rdata = 12'h456;
        exp_q.push_back({4'd1, model_rdata});
        exp_q.push_back({4'd3, model_rdata});
        req = 4'b1010;
        wait_done(20, d, rd, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if (d !== (4'b1 << e[15:12]) || rd !== e[11:0] || cyc !== 4) begin
            n_err++; $display("FAIL rst_mid_next: got done=%b rdata=%h cyc=%0d want done=%b rdata=%h cyc=4",
                              d, rd, cyc, 4'b1 << e[15:12], e[11:0]);
        end
        req[1] = 1'b0;
        wait_done(20, d, rd, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if (d !== (4'b1 << e[15:12]) || rd !== e[11:0] || cyc !== 7) begin
            n_err++; $display("FAIL rst_mid_b2b: got done=%b rdata=%h cyc=%0d want done=%b rdata=%h cyc=7",
                              d, rd, cyc, 4'b1 << e[15:12], e[11:0]);
        end
        req = '0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_drop();
        logic [15:0] e; logic [3:0] d; logic [11:0] rd; int cyc; logic seen;
        SSP_DO = 12'($urandom_range(0, 4095));
        set_client(3, 3'd7, 1'b0, 12'h000);
        model_rdata = SSP_DO;
        exp_q.push_back({4'd3, model_rdata});
        req = 4'b1000;
        repeat (2) @(negedge Clk);
        req = '0;
        wait_done(10, d, rd, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if (d !== (4'b1 << e[15:12]) || rd !== e[11:0] || cyc !== 2) begin
            n_err++; $display("FAIL drop_done: got done=%b rdata=%h cyc=%0d want done=%b rdata=%h cyc=2",
                              d, rd, cyc, 4'b1 << e[15:12], e[11:0]);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge Clk);
            if (SSP_SSEL || gnt !== 4'b0 || done !== 4'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL drop_no_refire: got second frame=%b want 0", seen);
        end
    endtask

`ifdef SSP_UART_IRQ_SVC_EN
    task automatic test_irq();
        logic [15:0] e; logic [3:0] d; logic [11:0] rd; int cyc;
        SSP_DO = 12'hABC;
        set_client(0, 3'd3, 1'b1, 12'h111);
        exp_q.push_back({4'd0, model_rdata});
        IRQ = 1'b1;
        req = 4'b0001;
        @(negedge Clk);
        IRQ = 1'b0;
        n_vec++;
        if ({SSP_SSEL, SSP_RA, SSP_WnR, gnt} !== {1'b1, 3'd1, 1'b0, 4'b0000}) begin
            n_err++; $display("FAIL irq_addr: got sel=%b ra=%h wnr=%b gnt=%b want 1 1 0 0000", SSP_SSEL, SSP_RA, SSP_WnR, gnt);
        end
        repeat (3) @(negedge Clk);
        n_vec++;
        if ({irq_status_vld, irq_status, done} !== {1'b1, 12'hABC, 4'b0000}) begin
            n_err++; $display("FAIL irq_status: got vld=%b status=%h done=%b want 1 abc 0000", irq_status_vld, irq_status, done);
        end
        SSP_DO = 12'h0F0;
        wait_done(20, d, rd, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if (d !== (4'b1 << e[15:12]) || rd !== e[11:0] || cyc !== 7) begin
            n_err++; $display("FAIL irq_then_req: got done=%b rdata=%h cyc=%0d want done=%b rdata=%h cyc=7",
                              d, rd, cyc, 4'b1 << e[15:12], e[11:0]);
        end
        req = '0;
        repeat (4) @(negedge Clk);
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_reset_mid();
        test_drop();
`ifdef SSP_UART_IRQ_SVC_EN
        test_irq();
`endif
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ssp_uart_access_arb.md
Name: ssp_uart_access_arb

Overview:
- Multi-requester access controller for the SSP UART register port.
- Arbitrates register-read and register-write requests from NUM_REQ on-chip clients using round-robin.
- Sequences each granted request as one SSP frame: SSP_SSEL, SSP_RA/SSP_WnR, SSP_En, then SSP_EOC.
- Returns read data to the granted client. Sits between system clients and the SSP slave port of the UART core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYC, 2, minimum idle cycles between consecutive frames (0..15).
- IRQ_STAT_RA, 3'd1, register address read automatically on IRQ (used only with the optional feature).

Ports:
- Clk  input  1  system clock.
- Rst  input  1  synchronous active-high reset.
- req  input  NUM_REQ  per-client request; held until that client's done pulse.
- req_ra  input  3*NUM_REQ  packed register addresses; client i uses bits [3i+2:3i].
- req_wnr  input  NUM_REQ  per-client command: 1 = write, 0 = read.
- req_wdata  input  12*NUM_REQ  packed write data; client i uses bits [12i+11:12i].
- gnt  output  NUM_REQ  one-hot grant; held for the whole frame.
- done  output  NUM_REQ  one-hot single-cycle completion pulse.
- rdata  output  12  read data; valid in the done cycle and held until the next done.
- busy  output  1  frame or gap in progress.
- SSP_SSEL  output  1  slave select.
- SSP_RA  output  3  register address.
- SSP_WnR  output  1  command to the UART.
- SSP_En  output  1  data-phase strobe.
- SSP_EOC  output  1  end-of-cycle strobe.
- SSP_DI  output  12  data to the UART.
- SSP_DO  input  12  data from the UART.
- IRQ  input  1  UART interrupt request (used only with the optional feature).

Behaviour:
- Reset values: all outputs 0, round-robin pointer = 0, FSM in IDLE, gap counter = 0.
- Reset mid-frame aborts the frame at the next edge. No done pulse is issued.
- FSM states:
  - IDLE: if any req, select the winner and go to ADDR. Otherwise stay.
  - ADDR: SSP_SSEL=1, SSP_RA and SSP_WnR driven from the winner, gnt asserted.
  - DATA: SSP_En=1; SSP_DI = winner wdata for a write, 0 for a read.
  - EOC: SSP_EOC=1, SSP_En=0; SSP_DO registered into rdata at the end of this cycle (rdata updated for reads only).
  - DONE: done[winner]=1, SSP_SSEL=0, gnt=0.
  - GAP: counts GAP_CYC cycles, then goes to IDLE. GAP is skipped when GAP_CYC=0.
- SSP_RA, SSP_WnR and SSP_DI are latched at IDLE->ADDR and held constant from ADDR through EOC.
- Timing: a req seen in IDLE at cycle 0 gives ADDR at cycle 1, DATA at 2, EOC at 3 and done at 4.
- Back-to-back throughput: one frame per 5+GAP_CYC cycles.
- Round-robin:
  - Search starts at the pointer. The lowest index at or after the pointer, with wrap-around, wins.
  - After a grant to client i, pointer = (i+1) mod NUM_REQ.
- A req dropped mid-frame is ignored; the frame completes and done still pulses.
- A req that arrives during a frame or gap waits for IDLE.
- busy = 1 in every state except IDLE.
- SSP_SSEL=1 only in ADDR, DATA and EOC.

Optional Feature:
- Macro: SSP_UART_IRQ_SVC_EN.
- When defined:
  - A rising IRQ sets a sticky irq_pend flag.
  - In IDLE, irq_pend has priority over all req inputs. An internal read frame to IRQ_STAT_RA runs, with no gnt or done asserted.
  - Adds ports irq_status (output, 12) and irq_status_vld (output, 1, single-cycle pulse in DONE). irq_pend clears in DONE.
  - The round-robin pointer is unchanged by the internal frame.
- When undefined: the IRQ input is ignored and the extra ports are absent.

Decomposition:
- Package ssp_uart_pkg holds:
  - the FSM state enum (IDLE, ADDR, DATA, EOC, DONE, GAP);
  - SSP_DW=12 and SSP_AW=3;
  - UART register address constants.
- One sub-module, ssp_rr_arb: combinational round-robin winner selection plus the registered pointer, parameterised by NUM_REQ.

Test Plan:
- Write: req[0], ra=3, wnr=1, wdata=0x5A5 -> cycle 1 SSP_RA=3, SSP_WnR=1; cycle 2 SSP_En=1, SSP_DI=0x5A5; cycle 3 SSP_EOC=1; cycle 4 done[0]=1.
- Read: req[2], ra=5, wnr=0, SSP_DO=0x123 in EOC -> done[2] with rdata=0x123; rdata holds 0x123 afterwards.
- Contention with all four req high, GAP_CYC=2 -> grants in order 0, 1, 2, 3, 0; done pulses spaced 7 cycles apart.
- Reset asserted during DATA -> next cycle all SSP outputs 0, no done, pointer=0; a following req[1] completes normally.
- With SSP_UART_IRQ_SVC_EN, IRQ pulse and req[0] simultaneously in IDLE -> internal read of RA=1 first; irq_status_vld=1 with irq_status=SSP_DO; then the req[0] frame runs.
- req[3] deasserted in DATA -> frame completes, done[3]=1, no second frame.
